fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 78 +++++++
 tb/tb_fifo_wr_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin funnel of N requesters into one FIFO write port, with occupancy tracking and stall
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*W-1:0]         req_data,
  input  logic                   fifo_full,
  input  logic                   fifo_rd,
  output logic [N-1:0]           gnt,
  output logic                   fifo_wr,
  output logic [W-1:0]           fifo_din,
  output logic [$clog2(DEPTH):0] occ,
  output logic                   stall
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = $clog2(DEPTH) + 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;
  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_last, w_win, w_idx;
  logic [N-1:0]  w_elig, w_gnt;
  logic [W-1:0]  w_din;
  logic          w_issue, w_dec, w_stall_nxt;
  logic [OW-1:0] w_occ_nxt;
  assign w_elig      = req & ~gnt;
  assign w_issue     = (|w_elig) && (occ < OW'(DEPTH)) && !fifo_full;
  assign w_dec       = fifo_rd && (occ != '0);
  assign w_occ_nxt   = occ + OW'(w_issue) - OW'(w_dec);
  assign w_stall_nxt = (|req) && ((w_occ_nxt == OW'(DEPTH)) || fifo_full);
  // Pick the first eligible requester after the last winner (scanning backwards so the nearest wins), then mux its grant and data
  always_comb begin
    w_win = r_last;
    w_idx = '0;
    w_gnt = '0;
    w_din = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = LW'((int'(r_last) + 1 + k) % N);
      if (w_elig[w_idx]) w_win = w_idx;
    end
    for (int i = 0; i < N; i++) begin
      w_gnt[i] = w_issue && (w_win == LW'(i));
      if (w_win == LW'(i)) w_din = req_data[i*W +: W];
    end
  end
  // Next state: a stall condition dominates, otherwise issuing keeps us ACTIVE
  always_comb begin
    w_state_nxt = IDLE;
    if (w_stall_nxt) w_state_nxt = STALL;
    else if (w_issue) w_state_nxt = ACTIVE;
    else if (r_state == ACTIVE && |w_elig) w_state_nxt = ACTIVE;
    else if (r_state == STALL && |req) w_state_nxt = STALL;
  end
  // Registered outputs; the pointer only moves on an issue, so it stays frozen while stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_last   <= LW'(N - 1);
      gnt      <= '0;
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
      occ      <= '0;
      stall    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      gnt     <= w_gnt;
      fifo_wr <= w_issue;
      occ     <= w_occ_nxt;
      stall   <= w_stall_nxt;
      if (w_issue) begin
        r_last   <= w_win;
        fifo_din <= w_din;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus with a write scoreboard checked by a negedge monitor
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, DEPTH = 8;
  logic           clk = 1'b0, rst = 1'b0, fifo_full = 1'b0, fifo_rd = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic           fifo_wr, stall;
  logic [W-1:0]   fifo_din;
  logic [3:0]     occ;
  logic [N+W-1:0] sb[$];
  logic [N+W-1:0] e;
  int n_cmp = 0, n_err = 0;

  fifo_wr_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .fifo_rd(fifo_rd), .gnt(gnt), .fifo_wr(fifo_wr), .fifo_din(fifo_din), .occ(occ), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [N-1:0] g, input logic [W-1:0] d);
    sb.push_back({g, d});
  endtask

  always @(negedge clk) begin
    chk("wr_is_or_gnt_onehot", {31'b0, fifo_wr == (|gnt) && $onehot0(gnt)}, 32'd1);
    if (fifo_wr) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got gnt=%b din=%h expected no write", gnt, fifo_din);
      end else begin
        e = sb.pop_front();
        chk("write", {20'b0, gnt, fifo_din}, {20'b0, e});
      end
    end
  end

  initial begin
    tick;
    tick;
    chk("rst_gnt", gnt, 0);
    chk("rst_wr", fifo_wr, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_occ", occ, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b1;
    req_data = 32'h13121110;
    req = 4'b1111;
    expect_wr(4'b0001, 8'h10);
    expect_wr(4'b0010, 8'h11);
    expect_wr(4'b0100, 8'h12);
    expect_wr(4'b1000, 8'h13);
    expect_wr(4'b0001, 8'h10);
    expect_wr(4'b0010, 8'h11);
    expect_wr(4'b0100, 8'h12);
    expect_wr(4'b1000, 8'h13);
    repeat (8) tick;
    chk("fill_occ", occ, 8);
    chk("fill_stall", stall, 1);
    tick;
    chk("full_wr", fifo_wr, 0);
    chk("full_gnt", gnt, 0);
    chk("full_occ", occ, 8);
    tick;
    chk("full_hold_wr", fifo_wr, 0);
    fifo_rd = 1'b1;
    tick;
    fifo_rd = 1'b0;
    chk("rd_occ", occ, 7);
    chk("rd_wr", fifo_wr, 0);
    expect_wr(4'b0001, 8'h10);
    tick;
    chk("refill_occ", occ, 8);
    chk("refill_stall", stall, 1);
    tick;
    chk("refill_nowr", fifo_wr, 0);
    chk("refill_occ2", occ, 8);
    req = 4'b0000;
    fifo_rd = 1'b1;
    repeat (3) tick;
    chk("drain5_occ", occ, 5);
    req = 4'b0100;
    expect_wr(4'b0100, 8'h12);
    tick;
    fifo_rd = 1'b0;
    chk("simul_occ", occ, 5);
    tick;
    chk("alt_gap1", gnt, 4'b0000);
    expect_wr(4'b0100, 8'h12);
    tick;
    chk("alt_gnt", gnt, 4'b0100);
    tick;
    chk("alt_gap2", gnt, 4'b0000);
    expect_wr(4'b0100, 8'h12);
    tick;
    chk("alt_occ", occ, 7);
    req = 4'b0000;
    fifo_rd = 1'b1;
    repeat (4) tick;
    fifo_rd = 1'b0;
    chk("drain3_occ", occ, 3);
    fifo_full = 1'b1;
    req = 4'b1111;
    tick;
    chk("ffull_gnt", gnt, 0);
    chk("ffull_stall", stall, 1);
    chk("ffull_occ", occ, 3);
    tick;
    chk("ffull_wr", fifo_wr, 0);
    fifo_full = 1'b0;
    expect_wr(4'b1000, 8'h13);
    tick;
    chk("resume_stall", stall, 0);
    chk("resume_occ", occ, 4);
    expect_wr(4'b0001, 8'h10);
    tick;
    expect_wr(4'b0010, 8'h11);
    tick;
    rst = 1'b0;
    tick;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_wr", fifo_wr, 0);
    chk("midrst_occ", occ, 0);
    chk("midrst_stall", stall, 0);
    rst = 1'b1;
    expect_wr(4'b0001, 8'h10);
    tick;
    chk("post_rst_gnt", gnt, 4'b0001);
    expect_wr(4'b0010, 8'h11);
    tick;
    req = 4'b0000;
    tick;
    tick;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
